// File: rtl/button_event_pkg.sv
// Shared types and helpers for the push-button event generator.
package button_event_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } key_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_event_one.sv
// Single-key event FSM: turns one debounced level into press/release/long/repeat pulses.
module button_event_one
    import button_event_pkg::*;
#(
    parameter int unsigned LONG_TICKS   = 800,
    parameter int unsigned REPEAT_TICKS = 150
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic key_in,
    output logic press,
    output logic release_evt,
    output logic long_press,
    output logic repeat_evt,
    output logic held
);

    localparam int unsigned CNT_W = $clog2(max_u(LONG_TICKS, REPEAT_TICKS) + 1);

    key_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic             press_c, release_c, long_c, repeat_c, held_c;

    // State, tick counter and registered event outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            press       <= 1'b0;
            release_evt <= 1'b0;
            long_press  <= 1'b0;
            repeat_evt  <= 1'b0;
            held        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            press       <= press_c;
            release_evt <= release_c;
            long_press  <= long_c;
            repeat_evt  <= repeat_c;
            held        <= held_c;
        end
    end

    assign cnt_inc = cnt + CNT_W'(1);

    // Next state; a release always wins over a threshold tick in the same cycle
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press_c   = 1'b0;
        release_c = 1'b0;
        long_c    = 1'b0;
        repeat_c  = 1'b0;
        case (state)
            IDLE: begin
                if (key_in) begin
                    press_c   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (!key_in) begin
                    release_c = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (tick) begin
                    if (cnt_inc == CNT_W'(LONG_TICKS)) begin
                        long_c    = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = REPEAT;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
            end
            REPEAT: begin
                if (!key_in) begin
                    release_c = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (tick) begin
                    if (cnt_inc == CNT_W'(REPEAT_TICKS)) begin
                        repeat_c = 1'b1;
                        cnt_nxt  = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        held_c = (state_nxt != IDLE);
    end

endmodule

// File: rtl/button_event_gen.sv
// Shared millisecond prescaler plus one independent event FSM per key.
// release/repeat are reserved words, so those event ports carry an _evt suffix.
module button_event_gen #(
    parameter int unsigned N_KEYS       = 4,
    parameter int unsigned TICK_DIV     = 27000,
    parameter int unsigned LONG_TICKS   = 800,
    parameter int unsigned REPEAT_TICKS = 150
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] press,
    output logic [N_KEYS-1:0] release_evt,
    output logic [N_KEYS-1:0] long_press,
    output logic [N_KEYS-1:0] repeat_evt,
    output logic [N_KEYS-1:0] held
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PRE_W-1:0] presc;
    logic             tick;

    assign tick = (presc == PRE_W'(TICK_DIV - 1));

    // Free-running prescaler, wraps on the tick cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PRE_W'(1);
        end
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        button_event_one #(
            .LONG_TICKS  (LONG_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS)
        ) u_key (
            .clk        (clk),
            .reset      (reset),
            .tick       (tick),
            .key_in     (key_in[g]),
            .press      (press[g]),
            .release_evt(release_evt[g]),
            .long_press (long_press[g]),
            .repeat_evt (repeat_evt[g]),
            .held       (held[g])
        );
    end

endmodule

// File: tb/tb_button_event_gen.sv
// Randomised and directed checks of button_event_gen against a tick-counting reference model.
module tb_button_event_gen;

    localparam int unsigned NK = 2;
    localparam int unsigned TD = 4;
    localparam int unsigned LT = 3;
    localparam int unsigned RT = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [NK-1:0] key_in;
    logic [NK-1:0] press, release_evt, long_press, repeat_evt, held;

    always #5 clk = ~clk;

    button_event_gen #(
        .N_KEYS      (NK),
        .TICK_DIV    (TD),
        .LONG_TICKS  (LT),
        .REPEAT_TICKS(RT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_in     (key_in),
        .press      (press),
        .release_evt(release_evt),
        .long_press (long_press),
        .repeat_evt (repeat_evt),
        .held       (held)
    );

    int vectors    = 0;
    int miscompares = 0;
    int now        = 0;

    // Reference model: edges since reset, and per key whether it is down and ticks seen since press
    int            edges_since_reset = 0;
    bit            mdl_down  [NK];
    int            mdl_ticks [NK];
    logic [NK-1:0] e_press, e_rel, e_long, e_rep, e_held;

    task automatic cycle(input logic [NK-1:0] k, input logic rst);
        bit tk;
        key_in = k;
        reset  = rst;
        @(posedge clk);
        e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
        if (rst) begin
            edges_since_reset = 0;
            for (int i = 0; i < NK; i++) begin
                mdl_down[i]  = 1'b0;
                mdl_ticks[i] = 0;
            end
        end else begin
            tk = ((edges_since_reset % TD) == TD - 1);
            for (int i = 0; i < NK; i++) begin
                if (mdl_down[i] && !k[i]) begin
                    e_rel[i]    = 1'b1;
                    mdl_down[i] = 1'b0;
                end else if (!mdl_down[i] && k[i]) begin
                    e_press[i]   = 1'b1;
                    mdl_down[i]  = 1'b1;
                    mdl_ticks[i] = 0;
                end else if (mdl_down[i] && tk) begin
                    mdl_ticks[i]++;
                    if (mdl_ticks[i] == LT)
                        e_long[i] = 1'b1;
                    else if (mdl_ticks[i] > LT && ((mdl_ticks[i] - LT) % RT) == 0)
                        e_rep[i] = 1'b1;
                end
            end
            edges_since_reset++;
        end
        for (int i = 0; i < NK; i++) e_held[i] = mdl_down[i];
        now++;
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 5; c++) begin
            cycle(2'b11, 1'b1);
            vectors++;
            if ({press, release_evt, long_press, repeat_evt, held} !== 10'd0) begin
                miscompares++;
                $display("FAIL reset_outputs t=%0d got=%b want=0", now,
                         {press, release_evt, long_press, repeat_evt, held});
            end
        end
        cycle(2'b11, 1'b0);
        vectors++;
        if (press !== 2'b11 || held !== 2'b11) begin
            miscompares++;
            $display("FAIL reset_first_press t=%0d press=%b held=%b want 11/11", now, press, held);
        end
    endtask

    task automatic test_short_press();
        int n_press = 0, n_held = 0, n_rel = 0, n_lr = 0;
        for (int c = 0; c < 3; c++) begin
            cycle(2'b00, 1'b0);
            vectors++;
            if ({press, release_evt, long_press, repeat_evt, held} !== {e_press, e_rel, e_long, e_rep, e_held}) begin
                miscompares++;
                $display("FAIL short_idle t=%0d got=%b want=%b", now,
                         {press, release_evt, long_press, repeat_evt, held}, {e_press, e_rel, e_long, e_rep, e_held});
            end
        end
        for (int c = 0; c < 8; c++) begin
            cycle((c < 5) ? 2'b01 : 2'b00, 1'b0);
            n_press += int'(press[0]);
            n_held  += int'(held[0]);
            n_rel   += int'(release_evt[0]);
            n_lr    += int'(long_press[0]) + int'(repeat_evt[0]);
            vectors++;
            if ({press, release_evt, long_press, repeat_evt, held} !== {e_press, e_rel, e_long, e_rep, e_held}) begin
                miscompares++;
                $display("FAIL short_press t=%0d got=%b want=%b", now,
                         {press, release_evt, long_press, repeat_evt, held}, {e_press, e_rel, e_long, e_rep, e_held});
            end
        end
        vectors++;
        if (n_press != 1 || n_held != 5 || n_rel != 1 || n_lr != 0) begin
            miscompares++;
            $display("FAIL short_counts press=%0d held=%0d rel=%0d lr=%0d want 1/5/1/0",
                     n_press, n_held, n_rel, n_lr);
        end
    endtask

    task automatic test_long_hold();
        int p_at = -1, l_at = -1, r_at = -1, n_rep = 0, prev;
        for (int c = 0; c < 40; c++) begin
            cycle(2'b01, 1'b0);
            vectors++;
            if ({press, release_evt, long_press, repeat_evt, held} !== {e_press, e_rel, e_long, e_rep, e_held}) begin
                miscompares++;
                $display("FAIL long_hold t=%0d got=%b want=%b", now,
                         {press, release_evt, long_press, repeat_evt, held}, {e_press, e_rel, e_long, e_rep, e_held});
            end
            if (press[0]) p_at = now;
            if (long_press[0]) l_at = now;
            if (repeat_evt[0]) begin
                prev = (r_at < 0) ? l_at : r_at;
                vectors++;
                if (prev < 0 || now - prev != int'(RT * TD)) begin
                    miscompares++;
                    $display("FAIL repeat_period t=%0d got=%0d want=%0d", now, now - prev, RT * TD);
                end
                r_at = now;
                n_rep++;
            end
        end
        vectors++;
        if (p_at < 0 || l_at < 0 || l_at - p_at < int'((LT - 1) * TD + 1) || l_at - p_at > int'(LT * TD)) begin
            miscompares++;
            $display("FAIL long_latency got=%0d want %0d..%0d", l_at - p_at, (LT - 1) * TD + 1, LT * TD);
        end
        vectors++;
        if (n_rep != 3) begin
            miscompares++;
            $display("FAIL repeat_count got=%0d want=3", n_rep);
        end
        cycle(2'b00, 1'b0);
        vectors++;
        if (release_evt !== 2'b01 || held !== 2'b00) begin
            miscompares++;
            $display("FAIL long_release rel=%b held=%b want 01/00", release_evt, held);
        end
    endtask

    task automatic test_release_on_threshold();
        int t = 0;
        bit long_seen = 1'b0, done = 1'b0;
        cycle(2'b01, 1'b0);
        vectors++;
        if (press !== 2'b01) begin
            miscompares++;
            $display("FAIL thr_press got=%b want=01", press);
        end
        for (int c = 0; c < 20 && !done; c++) begin
            if ((edges_since_reset % TD) == TD - 1 && t == LT - 1) begin
                cycle(2'b00, 1'b0);
                done = 1'b1;
                vectors++;
                if (release_evt[0] !== 1'b1 || long_press[0] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL thr_release rel=%b long=%b want 1/0", release_evt[0], long_press[0]);
                end
            end else begin
                if ((edges_since_reset % TD) == TD - 1) t++;
                cycle(2'b01, 1'b0);
            end
            long_seen |= long_press[0];
            vectors++;
            if ({press, release_evt, long_press, repeat_evt, held} !== {e_press, e_rel, e_long, e_rep, e_held}) begin
                miscompares++;
                $display("FAIL thr_cycle t=%0d got=%b want=%b", now,
                         {press, release_evt, long_press, repeat_evt, held}, {e_press, e_rel, e_long, e_rep, e_held});
            end
        end
        for (int c = 0; c < 16; c++) begin
            cycle(2'b00, 1'b0);
            long_seen |= long_press[0];
        end
        vectors++;
        if (!done || long_seen) begin
            miscompares++;
            $display("FAIL thr_no_long done=%0d long_seen=%0d want 1/0", done, long_seen);
        end
    endtask

    task automatic test_independent();
        int r_at = -1, l_at = -1, n_after = 0;
        cycle(2'b11, 1'b0);
        vectors++;
        if (press !== 2'b11) begin
            miscompares++;
            $display("FAIL both_press got=%b want=11", press);
        end
        for (int c = 0; c < 38; c++) begin
            cycle((c < 20) ? 2'b11 : 2'b01, 1'b0);
            vectors++;
            if ({press, release_evt, long_press, repeat_evt, held} !== {e_press, e_rel, e_long, e_rep, e_held}) begin
                miscompares++;
                $display("FAIL indep t=%0d got=%b want=%b", now,
                         {press, release_evt, long_press, repeat_evt, held}, {e_press, e_rel, e_long, e_rep, e_held});
            end
            if (long_press[0]) l_at = now;
            if (repeat_evt[0]) begin
                vectors++;
                if (now - ((r_at < 0) ? l_at : r_at) != int'(RT * TD)) begin
                    miscompares++;
                    $display("FAIL indep_cadence t=%0d got=%0d want=%0d", now,
                             now - ((r_at < 0) ? l_at : r_at), RT * TD);
                end
                r_at = now;
                if (c > 20) n_after++;
            end
        end
        vectors++;
        if (n_after < 2) begin
            miscompares++;
            $display("FAIL indep_repeats_after got=%0d want>=2", n_after);
        end
        cycle(2'b00, 1'b0);
    endtask

    task automatic test_reset_mid_hold();
        int p_at = -1, l_at = -1;
        for (int c = 0; c < 16; c++) cycle(2'b01, 1'b0);
        for (int c = 0; c < 3; c++) begin
            cycle(2'b01, 1'b1);
            vectors++;
            if ({press, release_evt, long_press, repeat_evt, held} !== 10'd0) begin
                miscompares++;
                $display("FAIL mid_reset t=%0d got=%b want=0", now,
                         {press, release_evt, long_press, repeat_evt, held});
            end
        end
        for (int c = 0; c < 20 && l_at < 0; c++) begin
            cycle(2'b01, 1'b0);
            vectors++;
            if ({press, release_evt, long_press, repeat_evt, held} !== {e_press, e_rel, e_long, e_rep, e_held}) begin
                miscompares++;
                $display("FAIL post_reset t=%0d got=%b want=%b", now,
                         {press, release_evt, long_press, repeat_evt, held}, {e_press, e_rel, e_long, e_rep, e_held});
            end
            if (press[0]) p_at = now;
            if (long_press[0]) l_at = now;
        end
        // Press lands on edge 0 after reset; ticks follow on edges 3, 7, 11
        vectors++;
        if (p_at < 0 || l_at - p_at != int'(LT * TD - 1)) begin
            miscompares++;
            $display("FAIL restart_latency got=%0d want=%0d", l_at - p_at, LT * TD - 1);
        end
        cycle(2'b00, 1'b0);
    endtask

    task automatic test_random();
        int            remain [NK];
        logic [NK-1:0] lvl = '0;
        for (int i = 0; i < NK; i++) remain[i] = 1;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NK; i++) begin
                remain[i]--;
                if (remain[i] <= 0) begin
                    lvl[i]    = ~lvl[i];
                    remain[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                            : int'($urandom_range(1, 40));
                end
            end
            cycle(lvl, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
            vectors++;
            if ({press, release_evt, long_press, repeat_evt, held} !== {e_press, e_rel, e_long, e_rep, e_held}) begin
                miscompares++;
                $display("FAIL random t=%0d key=%b got=%b want=%b", now, lvl,
                         {press, release_evt, long_press, repeat_evt, held}, {e_press, e_rel, e_long, e_rep, e_held});
            end
        end
    endtask

    initial begin
        key_in = '0;
        reset  = 1'b1;
        test_reset();
        test_short_press();
        test_long_hold();
        test_release_on_threshold();
        test_independent();
        test_reset_mid_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
